// File: rtl/adc_i2s_pkg.sv
// Shared types and constants for the WM8731-style ADC serial data source.
// Holds the FSM encoding, justification mode codes and counter helpers.
package adc_i2s_pkg;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        SLOT_L     = 2'd1,
        SLOT_R     = 2'd2
    } state_e;

    localparam int MODE_LJ     = 0;
    localparam int MODE_I2S    = 1;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/adc_frame_fifo.sv
// Synchronous first-word-fall-through FIFO for stereo frames.
// Pushes while full and pops while empty are ignored.
module adc_frame_fifo
    import adc_i2s_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        level_d  = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // storage carries no reset; the pointers define what is valid
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/adc_i2s_source.sv
// Emulated WM8731 ADC serial output: oversamples b_clk/adc_lr_clk on m_clk,
// pops one buffered stereo frame per frame clock and shifts it out MSB-first.
module adc_i2s_source
    import adc_i2s_pkg::*;
#(
    parameter int WIDTH    = 24,
    parameter int CHANNELS = 2,
    parameter int MODE     = 0,
    parameter int LR_POL   = 1,
    parameter int DEPTH    = 8
) (
    input  logic                     m_clk,
    input  logic                     rst_n,
    input  logic                     b_clk,
    input  logic                     adc_lr_clk,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [WIDTH-1:0]         s_left,
    input  logic [WIDTH-1:0]         s_right,
    output logic                     adcdat,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     underrun,
    output logic [CNT_W-1:0]         underrun_cnt,
    output logic [CNT_W-1:0]         frame_cnt
);

    localparam logic LR_LVL = 1'(LR_POL);

    logic [SYNC_STAGES-1:0] b_sync_q, b_sync_d, lr_sync_q, lr_sync_d;
    logic                   b_dly_q, b_dly_d, lr_dly_q, lr_dly_d;
    logic [1:0]             prime_q, prime_d;
    logic                   rdy_q;
    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       shift_q, shift_d, hold_q, hold_d;
    logic [1:0]             k_q, k_d;
    logic                   adcdat_q, adcdat_d, underrun_q, underrun_d;
    logic [CNT_W-1:0]       ucnt_q, ucnt_d, fcnt_q, fcnt_d;
    logic                   primed, b_fall, lr_now, lr_edge, frame_start;
    logic                   fifo_full, fifo_empty, push, pop;
    logic [2*WIDTH-1:0]     fifo_dout;
    logic [WIDTH-1:0]       fifo_l, fifo_r;

    // edges are masked until the chains have refilled after reset, so a pin
    // that is already high never looks like a fresh transition
    assign primed      = (prime_q == 2'(SYNC_STAGES + 1));
    assign lr_now      = lr_sync_q[SYNC_STAGES-1];
    assign b_fall      = primed && b_dly_q && !b_sync_q[SYNC_STAGES-1];
    assign lr_edge     = primed && (lr_now != lr_dly_q);
    assign frame_start = lr_edge && (lr_now == LR_LVL);

    assign s_ready      = rdy_q && !fifo_full;
    assign push         = s_valid && s_ready;
    assign fifo_l       = fifo_dout[WIDTH-1:0];
    assign fifo_r       = fifo_dout[2*WIDTH-1:WIDTH];
    assign adcdat       = adcdat_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = ucnt_q;
    assign frame_cnt    = fcnt_q;

    adc_frame_fifo #(
        .WIDTH (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (m_clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({s_right, s_left}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        b_sync_d  = {b_sync_q[SYNC_STAGES-2:0], b_clk};
        lr_sync_d = {lr_sync_q[SYNC_STAGES-2:0], adc_lr_clk};
        b_dly_d   = b_sync_q[SYNC_STAGES-1];
        lr_dly_d  = lr_sync_q[SYNC_STAGES-1];
        prime_d   = primed ? prime_q : prime_q + 2'd1;
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        k_d        = k_q;
        adcdat_d   = adcdat_q;
        underrun_d = 1'b0;
        ucnt_d     = ucnt_q;
        fcnt_d     = fcnt_q;
        pop        = 1'b0;

        if (frame_start) begin
            state_d = SLOT_L;
            fcnt_d  = fcnt_q + 1'b1;
            k_d     = 2'd0;
            if (!fifo_empty) begin
                pop     = 1'b1;
                shift_d = fifo_l;
                hold_d  = (CHANNELS == 1) ? fifo_l : fifo_r;
            end else begin
                shift_d    = '0;
                hold_d     = '0;
                underrun_d = 1'b1;
                ucnt_d     = sat_inc(ucnt_q);
            end
        end else if (lr_edge && state_q != WAIT_FRAME) begin
            state_d = SLOT_R;
            shift_d = hold_q;
            k_d     = 2'd0;
        end

        // a fall coinciding with the LR edge is the new slot's first fall;
        // the zero-filled shifter pads the slot once WIDTH bits are out
        if (b_fall && state_d != WAIT_FRAME) begin
            if (k_d != 2'd2) k_d = k_d + 2'd1;
            if (k_d > 2'(MODE)) begin
                adcdat_d = shift_d[WIDTH-1];
                shift_d  = {shift_d[WIDTH-2:0], 1'b0};
            end else begin
                adcdat_d = 1'b0;
            end
        end
    end

    always_ff @(posedge m_clk or negedge rst_n) begin
        if (!rst_n) begin
            b_sync_q   <= '0;
            lr_sync_q  <= '0;
            b_dly_q    <= 1'b0;
            lr_dly_q   <= 1'b0;
            prime_q    <= 2'd0;
            rdy_q      <= 1'b0;
            state_q    <= WAIT_FRAME;
            shift_q    <= '0;
            hold_q     <= '0;
            k_q        <= 2'd0;
            adcdat_q   <= 1'b0;
            underrun_q <= 1'b0;
            ucnt_q     <= '0;
            fcnt_q     <= '0;
        end else begin
            b_sync_q   <= b_sync_d;
            lr_sync_q  <= lr_sync_d;
            b_dly_q    <= b_dly_d;
            lr_dly_q   <= lr_dly_d;
            prime_q    <= prime_d;
            rdy_q      <= 1'b1;
            state_q    <= state_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            k_q        <= k_d;
            adcdat_q   <= adcdat_d;
            underrun_q <= underrun_d;
            ucnt_q     <= ucnt_d;
            fcnt_q     <= fcnt_d;
        end
    end

endmodule

// File: tb/tb_adc_i2s_source.sv
// Bench for adc_i2s_source: a stereo left-justified instance and a mono I2S
// instance share the codec clocks; a frame-queue scoreboard predicts each slot.
`timescale 1ns/1ps
module tb_adc_i2s_source;

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
    } frm_t;

    logic        m_clk = 1'b0, rst_n = 1'b0, b_clk = 1'b1, adc_lr_clk = 1'b0;
    logic        s_valid0 = 1'b0, s_valid1 = 1'b0;
    logic [23:0] s_left0 = '0, s_right0 = '0;
    logic [15:0] s_left1 = '0, s_right1 = '0;
    logic        s_ready0, s_ready1, adcdat0, adcdat1, underrun0, underrun1;
    logic [3:0]  fifo_level0;
    logic [2:0]  fifo_level1;
    logic [15:0] ucnt0, ucnt1, fcnt0, fcnt1;

    int   n_vec = 0, n_err = 0;
    int   fc0 = 0, ur0 = 0, fc1 = 0, ur1 = 0, seen0 = 0, seen1 = 0, nslot = 0;
    bit   st0 = 0, st1 = 0;
    frm_t q0[$], q1[$];
    frm_t cur0 = '{32'h0, 32'h0}, cur1 = '{32'h0, 32'h0};

    always #10 m_clk = ~m_clk;

    adc_i2s_source #(.WIDTH(24), .CHANNELS(2), .MODE(0), .LR_POL(1), .DEPTH(8)) dut0 (
        .m_clk(m_clk), .rst_n(rst_n), .b_clk(b_clk), .adc_lr_clk(adc_lr_clk),
        .s_valid(s_valid0), .s_ready(s_ready0), .s_left(s_left0), .s_right(s_right0),
        .adcdat(adcdat0), .fifo_level(fifo_level0), .underrun(underrun0),
        .underrun_cnt(ucnt0), .frame_cnt(fcnt0));

    adc_i2s_source #(.WIDTH(16), .CHANNELS(1), .MODE(1), .LR_POL(0), .DEPTH(4)) dut1 (
        .m_clk(m_clk), .rst_n(rst_n), .b_clk(b_clk), .adc_lr_clk(adc_lr_clk),
        .s_valid(s_valid1), .s_ready(s_ready1), .s_left(s_left1), .s_right(s_right1),
        .adcdat(adcdat1), .fifo_level(fifo_level1), .underrun(underrun1),
        .underrun_cnt(ucnt1), .frame_cnt(fcnt1));

    always @(posedge m_clk or negedge rst_n) begin
        if (!rst_n) begin
            seen0 <= 0;
            seen1 <= 0;
        end else begin
            if (underrun0) seen0 <= seen0 + 1;
            if (underrun1) seen1 <= seen1 + 1;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: run did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // slot image as seen at 32 b_clk rises: MSB lands after MODE leading falls
    function automatic logic [31:0] sw(input logic [31:0] s, input int w, input int mode);
        logic [31:0] v;
        v = s << (32 - w);
        v = v >> mode;
        return v;
    endfunction

    task automatic push0(input logic [31:0] l, input logic [31:0] r);
        @(negedge m_clk);
        s_valid0 = 1'b1; s_left0 = l[23:0]; s_right0 = r[23:0];
        @(negedge m_clk);
        s_valid0 = 1'b0;
        q0.push_back('{sw(l & 32'hFF_FFFF, 24, 0), sw(r & 32'hFF_FFFF, 24, 0)});
    endtask

    task automatic push1(input logic [31:0] l, input logic [31:0] r);
        @(negedge m_clk);
        s_valid1 = 1'b1; s_left1 = l[15:0]; s_right1 = r[15:0];
        @(negedge m_clk);
        s_valid1 = 1'b0;
        q1.push_back('{sw(l & 32'hFFFF, 16, 1), sw(l & 32'hFFFF, 16, 1)});
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, "_fcnt0"}, fcnt0, fc0);
        chk({tag, "_ucnt0"}, ucnt0, ur0);
        chk({tag, "_urpulse0"}, seen0, ur0);
        chk({tag, "_fcnt1"}, fcnt1, fc1);
        chk({tag, "_ucnt1"}, ucnt1, ur1);
        chk({tag, "_urpulse1"}, seen1, ur1);
    endtask

    // one 32-bit slot; LR changes together with the slot's first b_clk fall
    task automatic run_slot(input logic lr, input int rst_bit);
        logic [31:0] c0, c1, e0, e1, m;
        c0 = '0; c1 = '0;
        m  = (rst_bit >= 0) ? ~(32'hFFFF_FFFF >> (rst_bit + 1)) : 32'hFFFF_FFFF;
        if (lr == 1'b1) begin
            fc0++; st0 = 1;
            if (q0.size() > 0) cur0 = q0.pop_front();
            else begin cur0 = '{32'h0, 32'h0}; ur0++; end
            e0 = cur0.l;
            e1 = st1 ? cur1.r : 32'h0;
        end else begin
            fc1++; st1 = 1;
            if (q1.size() > 0) cur1 = q1.pop_front();
            else begin cur1 = '{32'h0, 32'h0}; ur1++; end
            e1 = cur1.l;
            e0 = st0 ? cur0.r : 32'h0;
        end
        @(negedge m_clk);
        b_clk = 1'b0; adc_lr_clk = lr;
        for (int i = 0; i < 32; i++) begin
            repeat (8) @(negedge m_clk);
            c0 = {c0[30:0], adcdat0};
            c1 = {c1[30:0], adcdat1};
            b_clk = 1'b1;
            if (i == rst_bit) begin
                repeat (4) @(negedge m_clk);
                chk("pre_rst_level0", fifo_level0, q0.size());
                rst_n = 1'b0;
                #1;
                chk("rst_adcdat0", adcdat0, 1'b0);
                chk("rst_level0", fifo_level0, 4'd0);
                chk("rst_adcdat1", adcdat1, 1'b0);
                q0.delete(); q1.delete();
                st0 = 0; st1 = 0; fc0 = 0; fc1 = 0; ur0 = 0; ur1 = 0;
                repeat (3) @(negedge m_clk);
                rst_n = 1'b1;
                repeat (1) @(negedge m_clk);
            end else begin
                repeat (8) @(negedge m_clk);
            end
            if (i != 31) b_clk = 1'b0;
        end
        nslot++;
        chk($sformatf("slot%0d_d0", nslot), c0 & m, e0 & m);
        chk($sformatf("slot%0d_d1", nslot), c1 & m, e1 & m);
    endtask

    initial begin
        // reset values
        repeat (3) @(negedge m_clk);
        chk("rst_adcdat", adcdat0, 1'b0);
        chk("rst_s_ready", {s_ready1, s_ready0}, 2'b00);
        chk("rst_level", fifo_level0, 4'd0);
        chk("rst_underrun", underrun0, 1'b0);
        chk("rst_cnts", {ucnt0, fcnt0}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge m_clk);
        chk("post_rst_s_ready", {s_ready1, s_ready0}, 2'b11);

        // first frame with nothing buffered: silent slots, one underrun each
        run_slot(1'b1, -1);
        run_slot(1'b0, -1);
        chk_stats("underrun");

        // known pattern plus two more frames, sent in order
        push0(32'hA5_0F3C, 32'h12_3456);
        push0($urandom, $urandom);
        push0($urandom, $urandom);
        push1(32'h8001, 32'h7777);
        push1($urandom, $urandom);
        push1(32'hFFFF, 32'h0);
        for (int i = 0; i < 3; i++) begin
            run_slot(1'b1, -1);
            run_slot(1'b0, -1);
        end
        chk_stats("ordered");

        // fill to DEPTH with no frame clocks; the 9th push is refused
        for (int i = 0; i < 9; i++) begin
            @(negedge m_clk);
            chk($sformatf("fill_ready%0d", i), s_ready0, (i < 8) ? 1'b1 : 1'b0);
            s_valid0 = 1'b1;
            s_left0  = 24'h10_0000 + 24'(i);
            s_right0 = 24'hF0_0000 - 24'(i);
            if (i < 8)
                q0.push_back('{sw(32'h10_0000 + i, 24, 0), sw(32'hF0_0000 - i, 24, 0)});
        end
        @(negedge m_clk);
        s_valid0 = 1'b0;
        chk("full_ready", s_ready0, 1'b0);
        chk("full_level", fifo_level0, 4'd8);
        run_slot(1'b1, -1);
        chk("drain1_level", fifo_level0, 4'd7);
        chk("drain1_ready", s_ready0, 1'b1);
        run_slot(1'b0, -1);
        for (int i = 0; i < 8; i++) begin
            run_slot(1'b1, -1);
            run_slot(1'b0, -1);
        end
        chk_stats("drained");

        // reset during the 10th bit of a left slot
        push0(32'h5A_C3E1, 32'h3C_0F0F);
        push0(32'h11_1111, 32'h22_2222);
        push1(32'h1234, 32'h0);
        run_slot(1'b1, 9);
        chk("post_rst_level", fifo_level0, 4'd0);
        run_slot(1'b0, -1);
        push0(32'h80_0001, 32'h7F_FFFE);
        push1(32'hC0DE, 32'h0);
        run_slot(1'b1, -1);
        run_slot(1'b0, -1);
        run_slot(1'b1, -1);
        chk_stats("resumed");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/adc_i2s_source.md
Name: adc_i2s_source

Overview:
- Synthesizable successor of the codec ADC functional model: emulates the WM8731 ADC serial output (adcdat) for bench and FPGA loopback.
- Runs on m_clk. Oversamples the codec-side b_clk/adc_lr_clk, buffers stereo frames in a FIFO, and serialises them.
- Parametrised sample width, channel count, justification mode and LR polarity.
- Adds underrun detection and frame statistics.

Parameters:
- WIDTH, 24, sample bits per channel (8..32); remaining slot bits are driven 0.
- CHANNELS, 2, 1 = mono (the left sample is sent in both slots), 2 = stereo.
- MODE, 0, 0 = left-justified (MSB on the 1st b_clk fall of a slot), 1 = I2S (MSB on the 2nd fall).
- LR_POL, 1, adc_lr_clk level that marks the left slot.
- DEPTH, 8, FIFO depth in frames; power of 2, ≥2.

Ports:
- m_clk  in  1  system clock; must be ≥8× b_clk.
- rst_n  in  1  asynchronous active-low reset.
- b_clk  in  1  bit clock, asynchronous, sampled.
- adc_lr_clk  in  1  frame clock, asynchronous, sampled.
- s_valid  in  1  frame write request.
- s_ready  out  1  FIFO not full.
- s_left  in  WIDTH  left sample.
- s_right  in  WIDTH  right sample; ignored when CHANNELS=1.
- adcdat  out  1  serial ADC data.
- fifo_level  out  $clog2(DEPTH)+1  frames stored.
- underrun  out  1  one-cycle pulse when a frame starts with the FIFO empty.
- underrun_cnt  out  16  saturating underrun count.
- frame_cnt  out  16  wrapping count of frames started.

Behaviour:
- Reset values (async, rst_n low): adcdat=0, s_ready=0 during reset then 1, fifo_level=0, underrun=0, both counters 0, state WAIT_FRAME, FIFO emptied.
- Synchronisers:
  - b_clk and adc_lr_clk each pass through a 2-FF synchroniser plus a delay FF.
  - An edge is detected 3 m_clk cycles after the pin edge.
  - adcdat changes in the m_clk cycle after a detected b_clk falling edge (total ≤4 m_clk cycles after the pin).
- FIFO:
  - Entry is {right,left}, 2*WIDTH bits.
  - A push happens when s_valid && s_ready.
  - s_ready = (fifo_level != DEPTH).
  - On a same-cycle push and pop, fifo_level is unchanged.
  - A push while full is dropped (s_ready is already low).
- Frame start:
  - Defined as a detected adc_lr_clk transition into the LR_POL level.
  - On frame start: frame_cnt++.
  - FIFO non-empty: pop, load the left sample into the shift register, load the right sample into the hold register.
  - FIFO empty: load zeros into both, pulse underrun, underrun_cnt++ (saturates at 16'hFFFF).
- States:
  - WAIT_FRAME: after reset; adcdat held 0; partial slots are ignored. Frame start → SLOT_L.
  - SLOT_L: falling-edge counter k starts at 0 on entry.
    - On each detected b_clk fall: k++. If k > MODE, drive the next shift bit MSB-first; once WIDTH bits are sent, drive 0.
    - Opposite adc_lr_clk transition → SLOT_R: load the right sample (left sample if CHANNELS=1), reset k.
  - SLOT_R: same bit rule. Frame start → SLOT_L (new pop).
- Slot boundaries:
  - A slot shorter than WIDTH+MODE b_clk falls is truncated silently. The next slot starts cleanly with MSB-first data.
  - A b_clk fall detected in the same cycle as an LR transition belongs to the new slot and counts as k=1.
- Reset mid-slot: immediate return to reset values; the frame in flight is lost. Serialisation resumes only at the next full frame start.
- Data order: MSB first; two's-complement samples pass through unchanged.

Decomposition:
- Package adc_i2s_pkg:
  - state encoding (WAIT_FRAME, SLOT_L, SLOT_R)
  - MODE_LJ=0, MODE_I2S=1
  - SYNC_STAGES=2
  - counter width constant 16
- Sub-module adc_frame_fifo:
  - parametrised synchronous FIFO (width 2*WIDTH, DEPTH), async active-low reset
  - ports: push/pop/full/empty/level
- Synchronisers, edge detection, FSM and shifter stay in the top module.

Test Plan:
1. Left-justified, WIDTH=24, MODE=0, LR_POL=1; m_clk 50 MHz, b_clk 3.072 MHz, 32 b_clk per slot; push left=24'hA5_0F3C, right=24'h12_3456.
   - Sampling adcdat at each b_clk rise yields A50F3C then 8 zeros in the left slot, then 123456 then 8 zeros in the right slot.
   - frame_cnt=1.
2. I2S, MODE=1, LR_POL=0, same data.
   - Every bit is delayed one b_clk; the slot's first bit is 0.
   - The left slot begins at the adc_lr_clk fall.
3. No push before the first frame.
   - adcdat stays 0 for the whole frame.
   - underrun pulses once; underrun_cnt=1.
   - Push 3 frames: they are sent in order, underrun_cnt stays 1.
4. DEPTH=8: push 9 frames back-to-back with no frame clocks.
   - s_ready falls after the 8th push; the 9th is rejected; fifo_level=8.
   - One frame start gives fifo_level=7 and s_ready=1.
5. CHANNELS=1, WIDTH=16, push left=16'h8001.
   - Both slots carry 8001 then 16 zeros.
6. Assert rst_n low in the middle of the 10th bit of a left slot.
   - adcdat=0 and fifo_level=0 immediately.
   - After release, adcdat stays 0 until the next LR_POL transition.
   - The next pushed frame is sent intact.
